// File: rtl/divisor_pkg.sv
// Shared definitions for the divider sequencer/arbiter: state encoding,
// default operand width and the requester index type.
package divisor_pkg;

    localparam int ANCHO_DEF = 16;

    typedef enum logic [2:0] {
        OCIOSO = 3'd0,
        CARGA  = 3'd1,
        ITERA  = 3'd2,
        FIN    = 3'd3,
        ESPERA = 3'd4
    } estado_t;

    // Index of the requester that currently owns the divider.
    typedef logic [0:0] idx_t;

endpackage

// File: rtl/divisor_datapath.sv
// Restoring shift-subtract divider datapath: operand, remainder, quotient and
// iteration counter registers, driven by the carga/paso strobes.
module divisor_datapath
    import divisor_pkg::*;
#(
    parameter int ANCHO = ANCHO_DEF
) (
    input  logic             reloj,
    input  logic             reset,
    input  logic             carga,
    input  logic             paso,
    input  logic [ANCHO-1:0] dividendo_i,
    input  logic [ANCHO-1:0] divisor_i,
    output logic [ANCHO-1:0] cociente_o,
    output logic [ANCHO-1:0] residuo_o,
    output logic             cuenta_cero_o,
    output logic             divisor_cero_o
);

    localparam int CW = $clog2(ANCHO + 1);

    // dq_q starts as the dividend and fills with quotient bits as it shifts out.
    logic [ANCHO-1:0] dq_q, dq_d;
    logic [ANCHO-1:0] dvs_q, dvs_d;
    logic [ANCHO:0]   rem_q, rem_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [ANCHO+1:0] despl;

    // NOTE: every variable gets a default before any branch so no latch is inferred.
    always_comb begin
        dq_d  = dq_q;
        dvs_d = dvs_q;
        rem_d = rem_q;
        cnt_d = cnt_q;
        despl = {rem_q, dq_q[ANCHO-1]};
        if (carga) begin
            dq_d  = dividendo_i;
            dvs_d = divisor_i;
            rem_d = '0;
            cnt_d = CW'(ANCHO);
        end else if (paso) begin
            if (despl >= {2'b00, dvs_q}) begin
                rem_d = (ANCHO+1)'(despl - {2'b00, dvs_q});
                dq_d  = {dq_q[ANCHO-2:0], 1'b1};
            end else begin
                rem_d = (ANCHO+1)'(despl);
                dq_d  = {dq_q[ANCHO-2:0], 1'b0};
            end
            cnt_d = cnt_q - CW'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of block ordering.
    always_ff @(posedge reloj) begin
        if (reset) begin
            dq_q  <= '0;
            dvs_q <= '0;
            rem_q <= '0;
            cnt_q <= '0;
        end else begin
            dq_q  <= dq_d;
            dvs_q <= dvs_d;
            rem_q <= rem_d;
            cnt_q <= cnt_d;
        end
    end

    assign cociente_o     = dq_q;
    assign residuo_o      = rem_q[ANCHO-1:0];
    // High during the last iteration: the counter hits zero on this step.
    assign cuenta_cero_o  = (cnt_q == CW'(1));
    assign divisor_cero_o = (divisor_i == '0);

endmodule

// File: rtl/divisor_arbitro.sv
// Two-requester arbiter and sequencer for the shared divider datapath.
// Define DIVISOR_RR_EN for round-robin arbitration; otherwise req0 has fixed priority.
module divisor_arbitro
    import divisor_pkg::*;
#(
    parameter int ANCHO = ANCHO_DEF
) (
    input  logic             reloj,
    input  logic             reset,
    input  logic             req0,
    input  logic             req1,
    input  logic [ANCHO-1:0] dividendo0,
    input  logic [ANCHO-1:0] divisor0,
    input  logic [ANCHO-1:0] dividendo1,
    input  logic [ANCHO-1:0] divisor1,
    output logic             ack0,
    output logic             ack1,
    output logic [ANCHO-1:0] cociente,
    output logic [ANCHO-1:0] residuo,
    output logic             error_div0,
    output logic             ocupado,
    output logic [2:0]       Est
);

    estado_t          est_q, est_d;
    idx_t             grant_q, grant_d, sel;
    logic             err_q, err_d;
    logic [ANCHO-1:0] coc_q, res_q, coc_fin, res_fin;
    logic [ANCHO-1:0] dp_coc, dp_res;
    logic             cuenta_cero, divisor_cero, req_conc;

    assign req_conc = grant_q[0] ? req1 : req0;

`ifdef DIVISOR_RR_EN
    idx_t ptr_q;

    always_ff @(posedge reloj) begin
        if (reset)
            ptr_q <= '0;
        else if (est_q == ESPERA && !req_conc)
            ptr_q <= ~grant_q;
    end

    assign sel = (req0 && req1) ? ptr_q : idx_t'(req1);
`else
    assign sel = idx_t'(!req0);
`endif

    divisor_datapath #(.ANCHO(ANCHO)) u_dp (
        .reloj          (reloj),
        .reset          (reset),
        .carga          (est_q == CARGA),
        .paso           (est_q == ITERA),
        .dividendo_i    (grant_q[0] ? dividendo1 : dividendo0),
        .divisor_i      (grant_q[0] ? divisor1 : divisor0),
        .cociente_o     (dp_coc),
        .residuo_o      (dp_res),
        .cuenta_cero_o  (cuenta_cero),
        .divisor_cero_o (divisor_cero)
    );

    always_ff @(posedge reloj) begin
        if (reset) begin
            est_q   <= OCIOSO;
            grant_q <= '0;
            err_q   <= 1'b0;
            coc_q   <= '0;
            res_q   <= '0;
        end else begin
            est_q   <= est_d;
            grant_q <= grant_d;
            err_q   <= err_d;
            if (est_q == FIN) begin
                coc_q <= coc_fin;
                res_q <= res_fin;
            end
        end
    end

    always_comb begin
        est_d   = est_q;
        grant_d = grant_q;
        err_d   = err_q;
        case (est_q)
            OCIOSO: if (req0 || req1) begin
                grant_d = sel;
                est_d   = CARGA;
            end
            CARGA: begin
                err_d = divisor_cero;
                est_d = divisor_cero ? FIN : ITERA;
            end
            ITERA:   if (cuenta_cero) est_d = FIN;
            FIN:     est_d = ESPERA;
            ESPERA:  if (!req_conc) est_d = OCIOSO;
            default: est_d = OCIOSO;
        endcase
    end

    // A zero divisor skips ITERA, so the quotient register still holds the dividend.
    assign coc_fin = err_q ? '1 : dp_coc;
    assign res_fin = err_q ? dp_coc : dp_res;

    always_comb begin
        ack0       = (est_q == FIN) && !grant_q[0];
        ack1       = (est_q == FIN) && grant_q[0];
        error_div0 = (est_q == FIN) && err_q;
        ocupado    = (est_q != OCIOSO);
        Est        = est_q;
        cociente   = (est_q == FIN) ? coc_fin : coc_q;
        residuo    = (est_q == FIN) ? res_fin : res_q;
    end

endmodule
